// File: rtl/seq_detector_param_moore.sv
// seq_detector_param_moore
// Parametrised Moore serial pattern detector with a runtime-programmable
// pattern, selectable overlapping/non-overlapping detection, an input
// qualifier and a saturating match counter. The detect output comes
// straight from a state register, so there is no combinational path
// from x to y.

module seq_detector_param_moore #(
  parameter int             N       = 3,
  parameter logic [N-1:0]   PATTERN = 3'b110,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             cfg_we,
  input  logic [N-1:0]     cfg_pattern,
  input  logic             cnt_clr,
  output logic             y,
  output logic [CNT_W-1:0] match_count
);

  localparam int               FILL_W    = $clog2(N + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_DETECT = 1'b1
  } det_state_t;

  det_state_t        state_q, state_d;
  logic [N-1:0]      pattern_q, pattern_d;
  logic [N-1:0]      hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [N-1:0]      hist_shift;
  logic [FILL_W-1:0] fill_inc;
  logic              accept;
  logic              match;

  // Candidate history/fill for an accepted bit and the resulting match flag
  always_comb begin
    hist_shift = {hist_q[N-2:0], x};
    fill_inc   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
    accept     = en && !cfg_we;
    match      = accept && (hist_shift == pattern_q) && (fill_inc == FILL_FULL);
  end

  // Next-state logic: a config write wins over data, en=0 holds everything
  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    count_d   = count_q;

    if (cfg_we) begin
      pattern_d = cfg_pattern;
      fill_d    = '0;
      state_d   = ST_IDLE;
    end else if (en) begin
      hist_d  = hist_shift;
      state_d = match ? ST_DETECT : ST_IDLE;
      if (match) begin
        fill_d = OVERLAP ? FILL_FULL : '0;
      end else begin
        fill_d = fill_inc;
      end
    end

    if (cnt_clr) begin
      count_d = '0;
    end else if (match && (count_q != CNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  // State registers with synchronous reset taking priority over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pattern_q <= PATTERN;
      hist_q    <= '0;
      fill_q    <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      count_q   <= count_d;
    end
  end

  assign y           = (state_q == ST_DETECT);
  assign match_count = count_q;

endmodule

// File: tb/tb_seq_detector_param_moore.sv
// tb_seq_detector_param_moore
// Drives four detector instances (default 110, 1010 overlapping,
// 1010 non-overlapping, 11 with a 2-bit counter) from one shared stream
// and checks them against directed expectations and a queue-based model.

module tb_seq_detector_param_moore;

  logic       clk = 1'b0;
  logic       rst, en, x, cfg_we, cnt_clr;
  logic [2:0] cfg_pattern3;
  logic [3:0] cfg_pattern4;
  logic [1:0] cfg_pattern2;

  logic       y0, y1, y2, y3;
  logic [7:0] cnt0, cnt1, cnt2;
  logic [1:0] cnt3;

  logic        act_y[4];
  logic [31:0] act_cnt[4];

  int checks   = 0;
  int failures = 0;

  // Reference model state: accepted bits since the window was last restarted
  bit          mq[4][$];
  logic [31:0] pat[4];
  int          exp_y[4];
  int          exp_cnt[4];
  int          mN[4]      = '{3, 4, 4, 2};
  bit          mOvl[4]    = '{1'b1, 1'b1, 1'b0, 1'b1};
  int          mMax[4]    = '{255, 255, 255, 3};
  logic [31:0] rstPat[4]  = '{32'b110, 32'b1010, 32'b1010, 32'b11};

  seq_detector_param_moore dut0 (
    .clk(clk), .rst(rst), .en(en), .x(x), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern3), .cnt_clr(cnt_clr), .y(y0), .match_count(cnt0));

  seq_detector_param_moore #(.N(4), .PATTERN(4'b1010), .OVERLAP(1'b1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .en(en), .x(x), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern4), .cnt_clr(cnt_clr), .y(y1), .match_count(cnt1));

  seq_detector_param_moore #(.N(4), .PATTERN(4'b1010), .OVERLAP(1'b0), .CNT_W(8)) dut2 (
    .clk(clk), .rst(rst), .en(en), .x(x), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern4), .cnt_clr(cnt_clr), .y(y2), .match_count(cnt2));

  seq_detector_param_moore #(.N(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(2)) dut3 (
    .clk(clk), .rst(rst), .en(en), .x(x), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern2), .cnt_clr(cnt_clr), .y(y3), .match_count(cnt3));

  assign act_y[0]   = y0;
  assign act_y[1]   = y1;
  assign act_y[2]   = y2;
  assign act_y[3]   = y3;
  assign act_cnt[0] = {24'd0, cnt0};
  assign act_cnt[1] = {24'd0, cnt1};
  assign act_cnt[2] = {24'd0, cnt2};
  assign act_cnt[3] = {30'd0, cnt3};

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] cfg_value(input int i);
    case (i)
      0:       return {29'd0, cfg_pattern3};
      3:       return {30'd0, cfg_pattern2};
      default: return {28'd0, cfg_pattern4};
    endcase
  endfunction

  function automatic bit window_matches(input int i);
    if (mq[i].size() != mN[i]) return 1'b0;
    for (int k = 0; k < mN[i]; k++) begin
      if (mq[i][k] != pat[i][mN[i]-1-k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_step();
    for (int i = 0; i < 4; i++) begin
      bit m;
      m = 1'b0;
      if (rst) begin
        pat[i] = rstPat[i];
        mq[i].delete();
        exp_y[i]   = 0;
        exp_cnt[i] = 0;
      end else begin
        if (cfg_we) begin
          pat[i] = cfg_value(i);
          mq[i].delete();
          exp_y[i] = 0;
        end else if (en) begin
          mq[i].push_back(x);
          if (mq[i].size() > mN[i]) void'(mq[i].pop_front());
          m = window_matches(i);
          exp_y[i] = m ? 1 : 0;
          if (m && !mOvl[i]) mq[i].delete();
        end
        if (cnt_clr) exp_cnt[i] = 0;
        else if (m && exp_cnt[i] < mMax[i]) exp_cnt[i]++;
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic xi,
                               input logic we, input logic clr,
                               input logic [2:0] p3, input logic [3:0] p4,
                               input logic [1:0] p2);
    @(negedge clk);
    rst          = r;
    en           = e;
    x            = xi;
    cfg_we       = we;
    cnt_clr      = clr;
    cfg_pattern3 = p3;
    cfg_pattern4 = p4;
    cfg_pattern2 = p2;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic feed(input logic e, input logic xi);
    applyStimulus(1'b0, e, xi, 1'b0, 1'b0, 3'b110, 4'b1010, 2'b11);
  endtask

  task automatic do_reset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b110, 4'b1010, 2'b11);
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (act_y[i] !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_y inst %0d: got %b expected 0", i, act_y[i]);
      end
      checks++;
      if (act_cnt[i] !== 32'd0) begin
        failures++;
        $display("[TB] FAIL reset_count inst %0d: got %0d expected 0", i, act_cnt[i]);
      end
    end
  endtask

  task automatic test_default_110();
    logic xs[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic ey[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int k = 0; k < 7; k++) begin
      feed(1'b1, xs[k]);
      checks++;
      if (y0 !== ey[k]) begin
        failures++;
        $display("[TB] FAIL default_110_y edge %0d: got %b expected %b", k + 1, y0, ey[k]);
      end
    end
    checks++;
    if (cnt0 !== 8'd2) begin
      failures++;
      $display("[TB] FAIL default_110_count: got %0d expected 2", cnt0);
    end
  endtask

  task automatic test_overlap_1010();
    logic eo[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic en_[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int k = 0; k < 8; k++) begin
      feed(1'b1, (k % 2 == 0) ? 1'b1 : 1'b0);
      checks++;
      if (y1 !== eo[k]) begin
        failures++;
        $display("[TB] FAIL overlap_y edge %0d: got %b expected %b", k + 1, y1, eo[k]);
      end
      checks++;
      if (y2 !== en_[k]) begin
        failures++;
        $display("[TB] FAIL nonoverlap_y edge %0d: got %b expected %b", k + 1, y2, en_[k]);
      end
    end
    checks++;
    if (cnt1 !== 8'd3) begin
      failures++;
      $display("[TB] FAIL overlap_count: got %0d expected 3", cnt1);
    end
    checks++;
    if (cnt2 !== 8'd2) begin
      failures++;
      $display("[TB] FAIL nonoverlap_count: got %0d expected 2", cnt2);
    end
  endtask

  task automatic test_enable_hold();
    logic es[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic xs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic ey[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int k = 0; k < 11; k++) begin
      feed(es[k], xs[k]);
      checks++;
      if (y0 !== ey[k]) begin
        failures++;
        $display("[TB] FAIL enable_hold_y step %0d: got %b expected %b", k, y0, ey[k]);
      end
    end
    checks++;
    if (cnt0 !== 8'd1) begin
      failures++;
      $display("[TB] FAIL enable_hold_count: got %0d expected 1", cnt0);
    end
  endtask

  task automatic test_runtime_config();
    logic xs[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic ey[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    feed(1'b1, 1'b1);
    feed(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b011, 4'b1010, 2'b11);
    checks++;
    if (y0 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL config_write_y: got %b expected 0", y0);
    end
    for (int k = 0; k < 4; k++) begin
      feed(1'b1, xs[k]);
      checks++;
      if (y0 !== ey[k]) begin
        failures++;
        $display("[TB] FAIL config_011_y step %0d: got %b expected %b", k, y0, ey[k]);
      end
    end
    checks++;
    if (cnt0 !== 8'd1) begin
      failures++;
      $display("[TB] FAIL config_count: got %0d expected 1", cnt0);
    end
  endtask

  task automatic test_reset_mid_pattern();
    logic xs[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic ey[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    feed(1'b1, 1'b1);
    feed(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'b001, 4'b0001, 2'b01);
    for (int k = 0; k < 4; k++) begin
      feed(1'b1, xs[k]);
      checks++;
      if (y0 !== ey[k]) begin
        failures++;
        $display("[TB] FAIL reset_mid_y step %0d: got %b expected %b", k, y0, ey[k]);
      end
    end
    checks++;
    if (cnt0 !== 8'd1) begin
      failures++;
      $display("[TB] FAIL reset_mid_count: got %0d expected 1", cnt0);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] ec[6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      feed(1'b1, 1'b1);
      checks++;
      if (cnt3 !== ec[k]) begin
        failures++;
        $display("[TB] FAIL saturate_count edge %0d: got %0d expected %0d", k + 1, cnt3, ec[k]);
      end
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'b110, 4'b1010, 2'b11);
    checks++;
    if (cnt3 !== 2'd0) begin
      failures++;
      $display("[TB] FAIL clear_wins_count: got %0d expected 0", cnt3);
    end
    checks++;
    if (y3 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL clear_wins_y: got %b expected 1", y3);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      logic r, e, xi, we, clr;
      r   = ($urandom_range(149) == 0);
      e   = ($urandom_range(3) != 0);
      xi  = $urandom_range(1);
      we  = ($urandom_range(39) == 0);
      clr = ($urandom_range(39) == 0);
      applyStimulus(r, e, xi, we, clr, 3'($urandom), 4'($urandom), 2'($urandom));
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (act_y[i] !== exp_y[i][0]) begin
          failures++;
          $display("[TB] FAIL random_y inst %0d cycle %0d: got %b expected %0d", i, n, act_y[i], exp_y[i]);
        end
        checks++;
        if (act_cnt[i] !== 32'(exp_cnt[i])) begin
          failures++;
          $display("[TB] FAIL random_count inst %0d cycle %0d: got %0d expected %0d", i, n, act_cnt[i], exp_cnt[i]);
        end
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    en           = 1'b0;
    x            = 1'b0;
    cfg_we       = 1'b0;
    cnt_clr      = 1'b0;
    cfg_pattern3 = 3'b110;
    cfg_pattern4 = 4'b1010;
    cfg_pattern2 = 2'b11;

    test_reset();
    test_default_110();
    test_overlap_1010();
    test_enable_hold();
    test_runtime_config();
    test_reset_mid_pattern();
    test_saturation();
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
